// File: rtl/bp_mem_cmd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bp_mem_cmd_arbiter_pkg
//   Shared types and helpers for bp_mem_cmd_arbiter.
//   - req_vec_t / req_idx_t : requester bit-vector and index, sized for the
//                             largest supported requester count (4).
//   - rr_pick()             : cyclic first-valid search starting at a pointer,
//                             behaviourally equivalent to bsg_arb_round_robin.
//   - rr_next()             : pointer advance, (g + 1) mod num_req.
// -----------------------------------------------------------------------------
package bp_mem_cmd_arbiter_pkg;

    localparam int max_num_req_lp = 4;
    localparam int req_idx_w_lp   = 2;

    typedef logic [max_num_req_lp-1:0] req_vec_t;
    typedef logic [req_idx_w_lp-1:0]   req_idx_t;

    typedef struct packed {
        logic     found;
        req_idx_t idx;
    } rr_pick_s;

    // Lowest-distance valid requester from ptr, wrapping at num_req.
    function automatic rr_pick_s rr_pick(input req_vec_t v,
                                         input req_idx_t ptr,
                                         input int       num_req);
        rr_pick_s pick;
        int       cand;
        req_idx_t cand_idx;
        pick = '0;
        for (int k = 0; k < max_num_req_lp; k++) begin
            cand     = (int'(ptr) + k) % num_req;
            cand_idx = req_idx_t'(cand);
            if ((k < num_req) && !pick.found && v[cand_idx]) begin
                pick.found = 1'b1;
                pick.idx   = cand_idx;
            end
        end
        return pick;
    endfunction

    function automatic req_idx_t rr_next(input req_idx_t g, input int num_req);
        return ((int'(g) + 1) == num_req) ? '0 : req_idx_t'(int'(g) + 1);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// -----------------------------------------------------------------------------
// bsg_fifo_1r1w_small
//   Small one-read/one-write FIFO with the basejump valid/ready-in,
//   valid/yumi-out handshake. Depth els_p must be a power of two (>= 2).
//   ready_param_o depends only on occupancy, so a pop never frees space for a
//   push in the same cycle. reset_i is active-high and asynchronous so the
//   FIFO clears together with the arbiter that owns it.
//   Ports:
//     clk_i, reset_i             clock, async active-high reset
//     v_i, ready_param_o, data_i write side (transfer on v_i & ready_param_o)
//     v_o, data_o, yumi_i        read side (yumi_i only while v_o)
// -----------------------------------------------------------------------------
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_param_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int lg_els_lp = (els_p > 2) ? $clog2(els_p) : 1;
    localparam int ptr_w_lp  = lg_els_lp + 1;

    typedef logic [ptr_w_lp-1:0] ptr_t;

    // Pointers carry one extra wrap bit to tell full from empty.
    ptr_t               wr_ptr_r, rd_ptr_r;
    logic [width_p-1:0] mem_r [els_p];
    logic               full, empty, enq, deq;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[lg_els_lp] != rd_ptr_r[lg_els_lp])
                 && (wr_ptr_r[lg_els_lp-1:0] == rd_ptr_r[lg_els_lp-1:0]);

    assign ready_param_o = ~full;
    assign v_o           = ~empty;
    assign data_o        = mem_r[rd_ptr_r[lg_els_lp-1:0]];

    assign enq = v_i & ~full;
    assign deq = yumi_i & ~empty;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            if (deq) rd_ptr_r <= rd_ptr_r + ptr_t'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are meaningful, and a reset-free array maps to plain RAM.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r[lg_els_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_mem_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// bp_mem_cmd_arbiter
//   Shares one in-order memory endpoint between num_req_p requesters.
//   Commands are round-robin granted into a registered slot; the winner's ID is
//   queued, and each in-order memory response is returned to the ID at the
//   queue head through a one-entry response buffer. Outstanding commands are
//   capped by the ID FIFO depth (max_outstanding_p).
//   Ports:
//     clk_i, reset_n_i                   clock, async active-low reset
//     req_cmd_i / _v_i / _ready_o        per-requester commands, one-hot grant
//     req_resp_o / _v_o / _yumi_i        broadcast response, one-hot owner
//     mem_cmd_o / _v_o / _yumi_i         command slot toward memory
//     mem_resp_i / _v_i / _ready_o       responses from memory
//     err_o                              sticky: response with nothing outstanding
// -----------------------------------------------------------------------------
module bp_mem_cmd_arbiter
    import bp_mem_cmd_arbiter_pkg::*;
#(
    parameter  int msg_width_p       = 0,
    parameter  int num_req_p         = 2,
    parameter  int max_outstanding_p = 4,
    localparam int lg_num_req_lp     = (num_req_p > 2) ? $clog2(num_req_p) : 1,
    // msg_width_p must be set by the wrapper; this keeps the unset default legal.
    localparam int msg_w_lp          = (msg_width_p > 0) ? msg_width_p : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [num_req_p*msg_w_lp-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]          req_cmd_v_i,
    output logic [num_req_p-1:0]          req_cmd_ready_o,

    output logic [msg_w_lp-1:0]           req_resp_o,
    output logic [num_req_p-1:0]          req_resp_v_o,
    input  logic [num_req_p-1:0]          req_resp_yumi_i,

    output logic [msg_w_lp-1:0]           mem_cmd_o,
    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_yumi_i,

    input  logic [msg_w_lp-1:0]           mem_resp_i,
    input  logic                          mem_resp_v_i,
    output logic                          mem_resp_ready_o,

    output logic                          err_o
);

    typedef logic [lg_num_req_lp-1:0] id_t;

    // ---------------- command path ----------------
    id_t                 rr_r;
    id_t                 grant_id;
    req_idx_t            rr_nxt;
    req_vec_t            req_v_pad;
    rr_pick_s            pick;
    logic                slot_free, can_issue, grant_v;
    logic                cmd_v_r;
    logic [msg_w_lp-1:0] cmd_r;

    // ---------------- ID FIFO ----------------
    logic                id_fifo_reset;
    logic                id_fifo_ready, id_fifo_v;
    id_t                 id_fifo_head;

    // ---------------- response path ----------------
    logic                resp_v_r;
    id_t                 resp_id_r;
    logic [msg_w_lp-1:0] resp_r;
    logic                resp_consume, resp_fire, resp_load, resp_unexpected;
    logic                err_r;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        req_v_pad                  = '0;
        req_v_pad[num_req_p-1:0]   = req_cmd_v_i;
        pick                       = rr_pick(req_v_pad, req_idx_t'(rr_r), num_req_p);
    end

    assign grant_id  = pick.idx[lg_num_req_lp-1:0];
    assign rr_nxt    = rr_next(req_idx_t'(grant_id), num_req_p);

    // The slot can take a new command in the same cycle it is drained.
    assign slot_free = ~cmd_v_r | mem_cmd_yumi_i;
    assign can_issue = slot_free & id_fifo_ready;
    // Upstream valids never depend on ready, so granting combinationally from
    // them is safe. Gating with reset keeps grants off while reset is held.
    assign grant_v   = reset_n_i & can_issue & pick.found;

    assign req_cmd_ready_o = grant_v ? (num_req_p'(1) << grant_id) : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_v_r <= 1'b0;
            rr_r    <= '0;
        end else if (grant_v) begin
            cmd_v_r <= 1'b1;
            rr_r    <= rr_nxt[lg_num_req_lp-1:0];
        end else if (mem_cmd_yumi_i) begin
            cmd_v_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant_v) cmd_r <= req_cmd_i[grant_id*msg_w_lp +: msg_w_lp];
    end

    assign mem_cmd_o   = cmd_r;
    assign mem_cmd_v_o = cmd_v_r;

    // ---------------- ID FIFO: one entry per outstanding command ----------------
    assign id_fifo_reset = ~reset_n_i;

    bsg_fifo_1r1w_small #(
        .width_p (lg_num_req_lp),
        .els_p   (max_outstanding_p)
    ) id_fifo (
        .clk_i         (clk_i),
        .reset_i       (id_fifo_reset),
        .v_i           (grant_v),
        .ready_param_o (id_fifo_ready),
        .data_i        (grant_id),
        .v_o           (id_fifo_v),
        .data_o        (id_fifo_head),
        .yumi_i        (resp_load)
    );

    // ---------------- response path ----------------
    assign resp_consume     = resp_v_r & req_resp_yumi_i[resp_id_r];
    assign mem_resp_ready_o = reset_n_i & (~resp_v_r | resp_consume);
    assign resp_fire        = mem_resp_v_i & mem_resp_ready_o;
    // Popping at buffer load makes FIFO occupancy equal the outstanding count.
    assign resp_load        = resp_fire & id_fifo_v;
    // A response with no owner is swallowed so memory cannot stall on it.
    assign resp_unexpected  = resp_fire & ~id_fifo_v;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v_r  <= 1'b0;
            resp_id_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (resp_load) begin
                resp_v_r  <= 1'b1;
                resp_id_r <= id_fifo_head;
            end else if (resp_consume) begin
                resp_v_r  <= 1'b0;
            end
            if (resp_unexpected) err_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (resp_load) resp_r <= mem_resp_i;
    end

    assign req_resp_o   = resp_r;
    assign req_resp_v_o = resp_v_r ? (num_req_p'(1) << resp_id_r) : '0;
    assign err_o        = err_r;

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_mem_cmd_arbiter
//   Cycle reference model (queues + plain arithmetic) plus per-requester
//   response scoreboard and an in-order memory model driving the DUT.
// -----------------------------------------------------------------------------
module tb_bp_mem_cmd_arbiter;

    localparam int W    = 32;
    localparam int N    = 2;
    localparam int MAXO = 4;
    localparam logic [W-1:0] RESP_XOR = 32'h5A5A_5A5A;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N*W-1:0]   req_cmd;
    logic [N-1:0]     req_cmd_v, req_cmd_ready;
    logic [W-1:0]     req_resp;
    logic [N-1:0]     req_resp_v, req_resp_yumi;
    logic [W-1:0]     mem_cmd, mem_resp;
    logic             mem_cmd_v, mem_cmd_yumi, mem_resp_v, mem_resp_ready, err;

    always #5 clk = ~clk;

    bp_mem_cmd_arbiter #(
        .msg_width_p       (W),
        .num_req_p         (N),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .req_cmd_i        (req_cmd),
        .req_cmd_v_i      (req_cmd_v),
        .req_cmd_ready_o  (req_cmd_ready),
        .req_resp_o       (req_resp),
        .req_resp_v_o     (req_resp_v),
        .req_resp_yumi_i  (req_resp_yumi),
        .mem_cmd_o        (mem_cmd),
        .mem_cmd_v_o      (mem_cmd_v),
        .mem_cmd_yumi_i   (mem_cmd_yumi),
        .mem_resp_i       (mem_resp),
        .mem_resp_v_i     (mem_resp_v),
        .mem_resp_ready_o (mem_resp_ready),
        .err_o            (err)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int           m_rr;
    bit           m_slot_v;
    logic [W-1:0] m_slot_d;
    int           m_idq[$];
    bit           m_buf_v;
    int           m_buf_id;
    logic [W-1:0] m_buf_d;
    bit           m_err;

    // bench memory, scoreboards, delivery log
    logic [W-1:0] mem_q[$];
    logic [W-1:0] sb[N][$];
    int           deliv_q[$];

    // values sampled at the negedge of the last step
    logic [N-1:0] obs_ready, obs_resp_v;
    logic         obs_cmd_v, obs_mrdy, obs_err;
    logic [W-1:0] obs_cmd, obs_resp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [N*W-1:0] rand_cmd();
        logic [N*W-1:0] c;
        for (int i = 0; i < N; i++) c[i*W +: W] = $urandom;
        return c;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_slot_v = 0; m_slot_d = '0; m_idq.delete();
        m_buf_v = 0; m_buf_id = 0; m_buf_d = '0; m_err = 0;
        mem_q.delete(); deliv_q.delete();
        for (int i = 0; i < N; i++) sb[i].delete();
    endtask

    // Spec grant rule evaluated against model state; -1 when nothing is granted.
    function automatic int model_grant();
        if (!((!m_slot_v || mem_cmd_yumi) && (m_idq.size() < MAXO))) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_cmd_v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs (called just after a posedge).
    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] cmd,
                         input logic [N-1:0] ymask, input bit cyumi, input bit rsp_en);
        req_cmd_v     = v;
        req_cmd       = cmd;
        req_resp_yumi = req_resp_v & ymask;
        mem_cmd_yumi  = mem_cmd_v & cyumi;
        if (rsp_en && (mem_q.size() > 0)) begin
            mem_resp_v = 1'b1;
            mem_resp   = mem_q[0] ^ RESP_XOR;
        end else begin
            mem_resp_v = 1'b0;
            mem_resp   = '0;
        end
    endtask

    // Sample at negedge, compare against the model, advance model and bench.
    task automatic step();
        int           g;
        bit           take, mrdy, load;
        logic [N-1:0] exp_rdy, exp_rv;
        logic [W-1:0] exp_d;
        @(negedge clk);
        obs_ready = req_cmd_ready; obs_resp_v = req_resp_v; obs_cmd_v = mem_cmd_v;
        obs_cmd = mem_cmd; obs_resp = req_resp; obs_mrdy = mem_resp_ready; obs_err = err;

        g       = model_grant();
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        exp_rv  = m_buf_v ? (N'(1) << m_buf_id) : '0;
        take    = m_buf_v && req_resp_yumi[m_buf_id];
        mrdy    = !m_buf_v || take;

        checks++;
        if (obs_ready !== exp_rdy) begin
            errors++; $display("FAIL cmd_ready: got %b want %b @%0t", obs_ready, exp_rdy, $time);
        end
        checks++;
        if (obs_cmd_v !== m_slot_v) begin
            errors++; $display("FAIL mem_cmd_v: got %b want %b @%0t", obs_cmd_v, m_slot_v, $time);
        end
        if (m_slot_v) begin
            checks++;
            if (obs_cmd !== m_slot_d) begin
                errors++; $display("FAIL mem_cmd: got %h want %h @%0t", obs_cmd, m_slot_d, $time);
            end
        end
        checks++;
        if (obs_resp_v !== exp_rv) begin
            errors++; $display("FAIL resp_v: got %b want %b @%0t", obs_resp_v, exp_rv, $time);
        end
        if (m_buf_v) begin
            checks++;
            if (obs_resp !== m_buf_d) begin
                errors++; $display("FAIL resp_data: got %h want %h @%0t", obs_resp, m_buf_d, $time);
            end
        end
        checks++;
        if (obs_mrdy !== mrdy) begin
            errors++; $display("FAIL mem_resp_ready: got %b want %b @%0t", obs_mrdy, mrdy, $time);
        end
        checks++;
        if (obs_err !== m_err) begin
            errors++; $display("FAIL err: got %b want %b @%0t", obs_err, m_err, $time);
        end

        // end-to-end scoreboard
        for (int i = 0; i < N; i++) begin
            if (req_cmd_v[i] && obs_ready[i]) sb[i].push_back(req_cmd[i*W +: W] ^ RESP_XOR);
            if (obs_resp_v[i] && req_resp_yumi[i]) begin
                deliv_q.push_back(i);
                checks++;
                if (sb[i].size() == 0) begin
                    errors++; $display("FAIL resp_extra: requester %0d got %h, none expected", i, obs_resp);
                end else begin
                    exp_d = sb[i].pop_front();
                    if (obs_resp !== exp_d) begin
                        errors++; $display("FAIL resp_route: requester %0d got %h want %h", i, obs_resp, exp_d);
                    end
                end
            end
        end

        // bench memory
        if (obs_mrdy && mem_resp_v && (mem_q.size() > 0)) void'(mem_q.pop_front());
        if (obs_cmd_v && mem_cmd_yumi) mem_q.push_back(obs_cmd);

        // model update
        load = 0;
        if (mem_resp_v && mrdy) begin
            if (m_idq.size() == 0) m_err = 1'b1;
            else begin
                load = 1; m_buf_id = m_idq.pop_front(); m_buf_d = mem_resp;
            end
        end
        if (load) m_buf_v = 1'b1;
        else if (take) m_buf_v = 1'b0;
        if (g >= 0) begin
            m_slot_v = 1'b1; m_slot_d = req_cmd[g*W +: W];
            m_rr = (g + 1) % N; m_idq.push_back(g);
        end else if (mem_cmd_yumi) begin
            m_slot_v = 1'b0;
        end

        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        req_cmd_v = '0; req_cmd = '0; req_resp_yumi = '0;
        mem_cmd_yumi = 1'b0; mem_resp_v = 1'b0; mem_resp = '0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drain(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            drive('0, rand_cmd(), '1, 1'b1, 1'b1);
            step();
        end
    endtask

    task automatic check_sb_empty(input string tag);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                errors++; $display("FAIL %s_lost: requester %0d still owed %0d responses, want 0", tag, i, sb[i].size());
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_cmd_v = '1; req_cmd = rand_cmd(); req_resp_yumi = '0;
        mem_cmd_yumi = 1'b0; mem_resp_v = 1'b0; mem_resp = '0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_cmd_ready !== '0 || mem_cmd_v !== 1'b0 || req_resp_v !== '0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b cmd_v=%b resp_v=%b err=%b, want all 0",
                         req_cmd_ready, mem_cmd_v, req_resp_v, err);
            end
        end
        @(posedge clk); #1 reset_n = 1'b1;
        drive('0, rand_cmd(), '1, 1'b1, 1'b0); step();
        drive('0, rand_cmd(), '1, 1'b1, 1'b0); step();
        checks++;
        if (obs_mrdy !== 1'b1) begin
            errors++; $display("FAIL reset_mem_resp_ready: got %b want 1", obs_mrdy);
        end
    endtask

    task automatic test_single();
        logic [W-1:0]   addrs [3];
        logic [N*W-1:0] c;
        addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0040; addrs[2] = 32'h8000_0080;
        apply_reset(2);
        for (int k = 0; k < 3; k++) begin
            c = rand_cmd(); c[0 +: W] = addrs[k];
            drive(2'b01, c, '1, 1'b1, 1'b0);
            step();
            checks++;
            if (obs_ready !== 2'b01) begin
                errors++; $display("FAIL single_grant%0d: got %b want 01", k, obs_ready);
            end
            if (k > 0) begin
                checks++;
                if (obs_cmd_v !== 1'b1 || obs_cmd !== addrs[k-1]) begin
                    errors++; $display("FAIL single_cmd%0d: got v=%b %h want 1 %h", k - 1, obs_cmd_v, obs_cmd, addrs[k-1]);
                end
            end
        end
        drive('0, rand_cmd(), '1, 1'b1, 1'b0);
        step();
        checks++;
        if (obs_cmd_v !== 1'b1 || obs_cmd !== addrs[2]) begin
            errors++; $display("FAIL single_cmd2: got v=%b %h want 1 %h", obs_cmd_v, obs_cmd, addrs[2]);
        end
        drain(12);
        checks++;
        if (deliv_q.size() != 3 || deliv_q[0] != 0 || deliv_q[1] != 0 || deliv_q[2] != 0) begin
            errors++; $display("FAIL single_resp: got %0d deliveries want 3 to requester 0", deliv_q.size());
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] want;
        apply_reset(2);
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, rand_cmd(), '1, 1'b1, 1'b1);
            step();
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (obs_ready !== want) begin
                errors++; $display("FAIL contention_grant%0d: got %b want %b", k, obs_ready, want);
            end
        end
        drain(15);
        checks++;
        if (deliv_q.size() != 6) begin
            errors++; $display("FAIL contention_count: got %0d want 6", deliv_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (deliv_q[k] != k % 2) begin
                    errors++; $display("FAIL contention_order%0d: got %0d want %0d", k, deliv_q[k], k % 2);
                end
            end
        end
        check_sb_empty("contention");
    endtask

    task automatic test_outstanding();
        int grants = 0;
        apply_reset(2);
        for (int k = 0; k < 8; k++) begin
            drive(2'b01, rand_cmd(), '1, 1'b1, 1'b0);
            step();
            if (obs_ready[0]) grants++;
            if (k >= 4) begin
                checks++;
                if (obs_ready !== 2'b00) begin
                    errors++; $display("FAIL limit_ready%0d: got %b want 00", k, obs_ready);
                end
            end
        end
        checks++;
        if (grants != MAXO) begin
            errors++; $display("FAIL limit_grants: got %0d want %0d", grants, MAXO);
        end
        // one response accepted: no bypass this cycle, one grant next cycle
        drive(2'b01, rand_cmd(), '1, 1'b1, 1'b1);
        step();
        checks++;
        if (obs_ready !== 2'b00 || obs_mrdy !== 1'b1) begin
            errors++; $display("FAIL limit_pop_cycle: got ready=%b mrdy=%b want 00 1", obs_ready, obs_mrdy);
        end
        grants = 0;
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, rand_cmd(), '1, 1'b1, 1'b0);
            step();
            if (obs_ready[0]) grants++;
            if (k == 0) begin
                checks++;
                if (obs_ready !== 2'b01) begin
                    errors++; $display("FAIL limit_regrant: got %b want 01", obs_ready);
                end
            end
        end
        checks++;
        if (grants != 1) begin
            errors++; $display("FAIL limit_extra_grants: got %0d want 1", grants);
        end
        drain(25);
        check_sb_empty("limit");
    endtask

    task automatic test_backpressure();
        int held = 0;
        apply_reset(2);
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, rand_cmd(), 2'b01, 1'b1, 1'b1);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive('0, rand_cmd(), 2'b01, 1'b1, 1'b1);
            step();
            if (obs_resp_v == 2'b10) begin
                held++;
                checks++;
                if (obs_mrdy !== 1'b0) begin
                    errors++; $display("FAIL bp_ready: got %b want 0 while buffer held", obs_mrdy);
                end
            end
        end
        checks++;
        if (held < 8) begin
            errors++; $display("FAIL bp_hold: buffer held for %0d cycles, want at least 8", held);
        end
        drain(20);
        checks++;
        if (deliv_q.size() != 4 || deliv_q[0] != 0 || deliv_q[1] != 1 || deliv_q[2] != 0 || deliv_q[3] != 1) begin
            errors++; $display("FAIL bp_order: got %0d deliveries, want 4 in order 0,1,0,1", deliv_q.size());
        end
        check_sb_empty("bp");
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int k = 0; k < 400; k++) begin
            drive(N'($urandom_range(0, 3)), rand_cmd(), N'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            step();
        end
        drain(30);
        check_sb_empty("random");
    endtask

    task automatic test_error_and_reset();
        apply_reset(2);
        drive('0, rand_cmd(), '1, 1'b1, 1'b0);
        mem_resp_v = 1'b1; mem_resp = 32'hDEAD_BEEF;
        step();
        checks++;
        if (obs_err !== 1'b0) begin
            errors++; $display("FAIL err_early: got %b want 0 in injection cycle", obs_err);
        end
        for (int k = 0; k < 4; k++) begin
            drive('0, rand_cmd(), '1, 1'b1, 1'b0);
            step();
            checks++;
            if (obs_err !== 1'b1) begin
                errors++; $display("FAIL err_sticky%0d: got %b want 1", k, obs_err);
            end
        end
        checks++;
        if (deliv_q.size() != 0) begin
            errors++; $display("FAIL err_dropped: got %0d deliveries want 0", deliv_q.size());
        end
        // build a burst with slot and buffer both full
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, rand_cmd(), 2'b00, 1'b1, 1'b1);
            step();
        end
        drive(2'b11, rand_cmd(), 2'b00, 1'b0, 1'b1);
        step();
        checks++;
        if (mem_cmd_v !== 1'b1 || req_resp_v !== 2'b01 || err !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: cmd_v=%b resp_v=%b err=%b want 1 01 1", mem_cmd_v, req_resp_v, err);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_cmd_v !== 1'b0 || req_resp_v !== 2'b00 || err !== 1'b0 || req_cmd_ready !== 2'b00) begin
            errors++; $display("FAIL midreset_async: cmd_v=%b resp_v=%b err=%b ready=%b want all 0",
                               mem_cmd_v, req_resp_v, err, req_cmd_ready);
        end
        apply_reset(2);
        drive(2'b10, rand_cmd(), '1, 1'b1, 1'b1);
        step();
        checks++;
        if (obs_ready !== 2'b10) begin
            errors++; $display("FAIL postreset_grant: got %b want 10", obs_ready);
        end
        drain(10);
        checks++;
        if (obs_err !== 1'b0) begin
            errors++; $display("FAIL postreset_err: got %b want 0", obs_err);
        end
        check_sb_empty("postreset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_outstanding();
        test_backpressure();
        test_random();
        test_error_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
